// File: rtl/vc_rr_arb_mux.sv
// vc_rr_arb_mux: round-robin N-to-1 val/rdy message mux with a one-entry registered output.
// Define VC_RR_ARB_MUX_LOCK_EN to hold the grant for the whole of a multi-beat packet (in_last).
module vc_rr_arb_mux #(
    parameter  int unsigned N  = 4,
    parameter  int unsigned W  = 32,
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   in_val,
    output logic [N-1:0]   in_rdy,
    input  logic [N-1:0]   in_last,
    input  logic [N*W-1:0] in_msg,
    output logic           out_val,
    input  logic           out_rdy,
    output logic [W-1:0]   out_msg,
    output logic           out_last,
    output logic [SW-1:0]  sel,
    output logic           busy
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_next;
    logic [SW-1:0] rr_grant;
    logic [SW-1:0] idx;
    logic [SW-1:0] grant;
    logic          can_load;
    logic          accept;
    logic          end_arb;
    logic [W-1:0]  msg_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_msg
        assign msg_arr[i] = in_msg[i*W +: W];
    end

    // Scan downward so the last hit is the first valid requester at or after ptr.
    always_comb begin
        rr_grant = ptr;
        idx      = '0;
        for (int unsigned k = N; k > 0; k--) begin
            idx = SW'((32'(ptr) + k - 1) % N);
            if (in_val[idx]) rr_grant = idx;
        end
    end

`ifdef VC_RR_ARB_MUX_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] lock_idx;
    logic [SW-1:0] lock_idx_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lock_idx <= '0;
        end else begin
            state    <= state_next;
            lock_idx <= lock_idx_next;
        end
    end

    always_comb begin
        state_next    = state;
        lock_idx_next = lock_idx;
        case (state)
            IDLE: begin
                if (accept && !in_last[grant]) begin
                    state_next    = LOCKED;
                    lock_idx_next = grant;
                end
            end
            LOCKED: begin
                if (accept && in_last[grant]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant   = (state == LOCKED) ? lock_idx : rr_grant;
    assign end_arb = accept & in_last[grant];
    assign busy    = (state == LOCKED);
`else
    assign grant   = rr_grant;
    assign end_arb = accept;
    assign busy    = 1'b0;
`endif

    assign can_load = ~out_val | out_rdy;
    assign accept   = can_load & in_val[grant];
    assign ptr_next = (grant == SW'(N - 1)) ? '0 : grant + 1'b1;

    // in_rdy is forced low while reset is asserted; accept itself need not be, as all state is held.
    always_comb begin
        in_rdy = '0;
        if (accept && reset_n) in_rdy[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_val  <= 1'b0;
            out_msg  <= '0;
            out_last <= 1'b0;
            sel      <= '0;
            ptr      <= '0;
        end else begin
            if (accept) begin
                out_val  <= 1'b1;
                out_msg  <= msg_arr[grant];
                out_last <= in_last[grant];
                sel      <= grant;
            end else if (out_rdy) begin
                out_val  <= 1'b0;
            end
            if (end_arb) ptr <= ptr_next;
        end
    end

endmodule
